// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Latency: grant at the request edge, tx_start one cycle later, done/timeout reported at the done-edge.
// Backpressure: one transfer in flight; other requests wait (level-held) until the next IDLE cycle.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [NUM_REQ-1:0]          req_in,
  input  logic [NUM_REQ*DATA_W-1:0]   data_in,
  output logic [NUM_REQ-1:0]          grant_out,
  output logic [NUM_REQ-1:0]          done_out,
  output logic                        err_timeout_out,
  output logic                        busy_out,
  output logic                        tx_start_out,
  output logic [DATA_W-1:0]           tx_data_out,
  input  logic                        tx_done_in
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  // Counter value at which the wait is abandoned, and its saturation ceiling.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic [PTR_W-1:0]      r_rr_ptr,     w_rr_ptr_nxt;
  logic [PTR_W-1:0]      r_owner,      w_owner_nxt;
  logic [CNT_W-1:0]      r_cnt,        w_cnt_nxt;
  logic [DATA_W-1:0]     r_tx_data,    w_tx_data_nxt;
  logic [NUM_REQ-1:0]    r_grant,      w_grant_nxt;
  logic [NUM_REQ-1:0]    r_done,       w_done_nxt;
  logic                  r_err,        w_err_nxt;
  logic                  r_tx_start,   w_tx_start_nxt;
  logic                  r_done_q;

  logic                  w_req_any;
  logic [PTR_W-1:0]      w_sel;
  logic [DATA_W-1:0]     w_sel_data;
  logic [PTR_W-1:0]      w_owner_inc;
  logic                  w_done_edge;

  // Rising edge of the UART done flag; a level held high produces a single edge.
  assign w_done_edge = tx_done_in & ~r_done_q;

  // Pointer value used after the current owner finishes (wraps at NUM_REQ-1).
  assign w_owner_inc = (r_owner == PTR_LAST) ? '0 : r_owner + 1'b1;

  // Round-robin pick: first requesting index at or above rr_ptr, modulo NUM_REQ.
  always_comb begin
    w_req_any = 1'b0;
    w_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_req_any && req_in[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
        w_req_any = 1'b1;
        w_sel     = PTR_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // Byte of the selected requester, captured only on a grant.
  assign w_sel_data = data_in[int'(w_sel)*DATA_W +: DATA_W];

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_cnt_nxt      = r_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_grant_nxt    = '0;
    w_done_nxt     = '0;
    w_err_nxt      = 1'b0;
    w_tx_start_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_owner_nxt   = w_sel;
          w_tx_data_nxt = w_sel_data;
          w_grant_nxt   = NUM_REQ'(1) << w_sel;
          w_state_nxt   = S_START;
        end
      end

      S_START: begin
        w_tx_start_nxt = 1'b1;
        w_cnt_nxt      = '0;
        w_state_nxt    = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        // A done edge wins over a timeout expiring in the same cycle.
        if (w_done_edge) begin
          w_done_nxt   = NUM_REQ'(1) << r_owner;
          w_rr_ptr_nxt = w_owner_inc;
          w_state_nxt  = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_err_nxt    = 1'b1;
          w_rr_ptr_nxt = w_owner_inc;
          w_state_nxt  = S_IDLE;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_tx_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_tx_start <= w_tx_start_nxt;
    end
  end

  // Done flag history, tracked in every state so stale levels never look like edges.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= tx_done_in;
    end
  end

  assign grant_out       = r_grant;
  assign done_out        = r_done;
  assign err_timeout_out = r_err;
  assign busy_out        = (r_state != S_IDLE);
  assign tx_start_out    = r_tx_start;
  assign tx_data_out     = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized transfers.
// Latency: checks grant, start, done and timeout cycle positions against a transaction model.
// Backpressure: requests held or changed randomly while a transfer is in flight.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 100;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic [N-1:0]     req_in;
  logic [N*W-1:0]   data_in;
  logic [N-1:0]     grant_out;
  logic [N-1:0]     done_out;
  logic             err_timeout_out;
  logic             busy_out;
  logic             tx_start_out;
  logic [W-1:0]     tx_data_out;
  logic             tx_done_in;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: round-robin pointer and the byte last handed to the UART.
  int         m_ptr = 0;
  logic [W-1:0] m_last_byte = '0;

  always #5 clk_in = ~clk_in;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .req_in          (req_in),
    .data_in         (data_in),
    .grant_out       (grant_out),
    .done_out        (done_out),
    .err_timeout_out (err_timeout_out),
    .busy_out        (busy_out),
    .tx_start_out    (tx_start_out),
    .tx_data_out     (tx_data_out),
    .tx_done_in      (tx_done_in)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // Fair pick: first set request at or after the pointer, walking around the ring.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // One complete transfer: grant, start, then either a done edge after 'delay'
  // wait cycles or no edge at all (timeout). Inputs change right after an edge.
  task automatic xfer(input logic [N-1:0] req, input logic [N*W-1:0] dat,
                      input int delay, input bit timeout,
                      input logic [N-1:0] req_after, input bit done_level,
                      output int owner);
    int         exp_o;
    logic [W-1:0] exp_b;
    int         n;
    bit         bad;
    exp_o  = pick(req, m_ptr);
    exp_b  = dat[exp_o*W +: W];
    owner  = exp_o;
    req_in  = req;
    data_in = dat;
    tick;
    check("grant_onehot", grant_out, 32'(1) << exp_o);
    check("grant_data", tx_data_out, exp_b);
    check("busy_on_grant", busy_out, 1);
    check("no_start_on_grant", tx_start_out, 0);
    check("pulses_clear", {err_timeout_out, done_out}, 0);
    req_in  = req_after;
    data_in = $urandom;
    tick;
    check("start_pulse", tx_start_out, 1);
    check("grant_single", grant_out, 0);
    bad = 0;
    if (timeout) begin
      n = 0;
      do begin
        tick;
        n++;
        if (done_out != 0 || grant_out != 0 || tx_start_out) bad = 1;
      end while (!err_timeout_out && n < 3*TO);
      check("timeout_latency", n, TO);
      check("timeout_err", err_timeout_out, 1);
      check("timeout_quiet", bad, 0);
      check("timeout_idle", busy_out, 0);
      check("timeout_data_hold", tx_data_out, exp_b);
    end else begin
      for (int d = 0; d < delay; d++) begin
        tick;
        if (done_out != 0 || err_timeout_out || grant_out != 0 || tx_start_out ||
            !busy_out || tx_data_out != exp_b) bad = 1;
      end
      // A flag still high from the previous frame must fall before it can count.
      if (tx_done_in) begin
        tx_done_in = 1'b0;
        tick;
        if (done_out != 0 || err_timeout_out || !busy_out) bad = 1;
      end
      check("wait_quiet", bad, 0);
      tx_done_in = 1'b1;
      tick;
      check("done_onehot", done_out, 32'(1) << exp_o);
      check("done_no_err", err_timeout_out, 0);
      check("done_idle", busy_out, 0);
      check("done_data_hold", tx_data_out, exp_b);
      if (!done_level) tx_done_in = 1'b0;
    end
    m_ptr       = (exp_o + 1) % N;
    m_last_byte = exp_b;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checked", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int o;
    int exp_seq[$];
    bit bad;
    rst_n_in   = 1'b0;
    req_in     = '0;
    data_in    = '0;
    tx_done_in = 1'b0;
    repeat (3) tick;
    check("rst_outputs", {grant_out, done_out, err_timeout_out, busy_out, tx_start_out, tx_data_out}, 0);
    rst_n_in = 1'b1;
    tick;
    check("idle_no_req", {grant_out, busy_out}, 0);

    // Single request: requester 2 with 0xA5, done 50 cycles after start.
    xfer(4'b0100, 32'h00A5_0000, 49, 0, 4'b0000, 0, o);
    check("single_owner", o, 2);

    // Pointer fairness after requester 2: 1101 serves 3, 0, 2.
    exp_seq = '{3, 0, 2};
    foreach (exp_seq[i]) begin
      xfer(4'b1101, $urandom, $urandom_range(0, 20), 0, 4'b1101, 0, o);
      check("fair_order", o, exp_seq[i]);
    end

    // Round-robin from reset with all four requesting.
    rst_n_in = 1'b0; req_in = '0; tick; rst_n_in = 1'b1; m_ptr = 0;
    exp_seq = '{0, 1, 2, 3, 0};
    foreach (exp_seq[i]) begin
      xfer(4'b1111, 32'h4332_2110, $urandom_range(0, 30), 0, 4'b1111, 0, o);
      check("rr_order", o, exp_seq[i]);
    end

    // Timeout with the done flag stuck low, then the pointer must have moved on.
    xfer(4'b0010, $urandom, 0, 1, 4'b0000, 0, o);
    check("timeout_owner", o, 1);
    xfer(4'b1111, $urandom, 5, 0, 4'b0000, 0, o);
    check("ptr_after_timeout", o, 2);

    // Done edge landing on the last timeout cycle counts as done.
    xfer(4'b1000, $urandom, TO-1, 0, 4'b0000, 0, o);

    // Stale level: leave the flag high across IDLE and START of the next frame.
    xfer(4'b0001, $urandom, 3, 0, 4'b0000, 1, o);
    xfer(4'b0001, $urandom, 10, 0, 4'b0000, 0, o);

    // Reset during WAIT_DONE: everything clears, later done edge is not reported.
    req_in = 4'b0001; data_in = $urandom;
    tick; tick; req_in = '0;
    repeat (3) tick;
    check("pre_reset_busy", busy_out, 1);
    rst_n_in = 1'b0;
    tick;
    check("midrst_outputs", {grant_out, done_out, err_timeout_out, busy_out, tx_start_out, tx_data_out}, 0);
    rst_n_in = 1'b1;
    m_ptr = 0; m_last_byte = '0;
    tx_done_in = 1'b1;
    bad = 0;
    repeat (4) begin
      tick;
      if (done_out != 0 || busy_out || err_timeout_out) bad = 1;
    end
    check("midrst_no_done", bad, 0);
    tx_done_in = 1'b0;

    // Randomized transfers with idle gaps, stray done activity and changing requests.
    for (int t = 0; t < 40; t++) begin
      xfer(N'($urandom_range(1, 15)), $urandom, $urandom_range(0, 60),
           ($urandom_range(0, 7) == 0), N'($urandom), bit'($urandom_range(0, 1)), o);
      if ($urandom_range(0, 3) == 0) begin
        req_in = '0;
        bad = 0;
        repeat ($urandom_range(1, 4)) begin
          tx_done_in = bit'($urandom_range(0, 1));
          tick;
          if (grant_out != 0 || done_out != 0 || busy_out || tx_data_out != m_last_byte) bad = 1;
        end
        check("idle_gap_quiet", bad, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
